usb_dev: RTL and testbench
==========================

# usb_dev

Device-side link endpoint: the far end of the host USB bridge's nibble/serial link. It receives serial command frames from the host's 1-bit transmit line and decodes them into a 32-bit command word. It sends typed data packets back on the host's 4-bit receive bus, streaming payload bytes from a local synchronous RAM. Command receive and packet transmit are full-duplex and independent.

## Interface
- RAM_AW, 12, payload RAM address width and length-field width (max payload 2^RAM_AW−1 bytes)
- clk  in  1  link clock; one serial bit in and one nibble out per cycle
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- cmd_rxd  in  1  serial command line from host, MSB first, idle high
- cmd  out  32  last valid command word, held until next valid frame
- cmd_vld  out  1  one-cycle pulse, cmd updated
- cmd_err  out  1  one-cycle pulse, checksum mismatch; cmd unchanged
- fs_send  in  1  start packet; sampled only in TX IDLE
- send_btype  in  4  packet type; latched on accepted fs_send
- send_len  in  RAM_AW  payload byte count; latched on accepted fs_send; 0 legal
- fd_send  out  1  one-cycle pulse, packet finished
- busy  out  1  high from the cycle after fs_send is accepted until fd_send
- ram_rxa  out  RAM_AW  payload read address
- ram_rxd  in  8  payload data, valid one cycle after ram_rxa
- data_txd  out  4  nibble bus to host
- data_txen  out  1  high while data_txd carries packet nibbles

## Operation
- Reset values: cmd=0, cmd_vld=0, cmd_err=0, fd_send=0, busy=0, ram_rxa=0, data_txd=0, data_txen=0. Both FSMs go to their first state.
- RX FSM: HUNT → CMD → CHK → HUNT.
  - HUNT: shift cmd_rxd into a 16-bit register and match 0x55D5.
  - CMD: shift in 32 bits, MSB first.
  - CHK: shift in 8 bits and compare against the XOR of the 4 command bytes.
  - On match: cmd is loaded and cmd_vld pulses. On mismatch: cmd_err pulses.
  - On leaving CHK, the sync register is cleared, so sync bits inside the payload are never reused.
- TX FSM: IDLE → PRE → TYPE → DATA → CSUM → IDLE.
  - PRE: nibbles 0x5, 0x5, 0x5, 0xD.
  - TYPE: one nibble, send_btype.
  - DATA: each byte high nibble first, then low nibble. Bytes are read from addresses 0..len−1.
  - CSUM: XOR of all payload bytes, high nibble then low nibble. The checksum is 0x00 when len=0, and DATA is skipped.
- Width rules: the byte counter is RAM_AW bits. ram_rxa never exceeds len−1 during DATA. ram_rxa returns to 0 in IDLE.
- fs_send while busy is ignored and not queued.
- RX and TX never interact. A command arriving mid-packet does not disturb the packet.
- Reset asserted mid-frame aborts both FSMs immediately. There is no fd_send and no cmd_vld for an aborted frame.

## Timing
- Cycle T = the edge at which fs_send=1 is sampled in IDLE.
- First preamble nibble (0x5, data_txen=1) appears at T+1.
- TYPE nibble appears at T+5.
- Byte i high nibble appears at T+6+2i; low nibble at T+7+2i.
- Checksum nibbles appear at T+6+2N and T+7+2N.
- fd_send pulses, and data_txen drops to 0 with data_txd=0, at T+8+2N. busy falls on the same cycle.
- Packet length is 7+2N nibble cycles.
- The earliest next accepted fs_send is at edge T+8+2N, giving back-to-back packets with no gap.
- ram_rxa=i is driven at least two cycles before byte i's high nibble. The block buffers the byte internally; data_txd is registered.
- RX: cmd_vld/cmd_err pulse in the cycle after the last checksum bit is sampled, i.e. 56 cycles after the first sync bit. The new cmd is visible in the same cycle as cmd_vld.
- A sync pattern starting the cycle after the checksum's last bit is detected; there is no dead time.

## Test plan
- Serial 0x55,0xD5,0x12345678,0x08 → cmd=0x12345678, single cmd_vld pulse 56 cycles after first bit, no cmd_err.
- Same frame with checksum 0x09 → cmd_err pulse, cmd keeps prior value, next good frame accepted.
- fs_send, btype=0x3, len=3, RAM[0..2]=0xA1,0xB2,0xC3 (1-cycle RAM model) → nibbles 5,5,5,D,3,A,1,B,2,C,3,D,0 at T+1..T+13. fd_send at T+14. ram_rxa stays ≤2.
- len=0, btype=0xF → nibbles 5,5,5,D,F,0,0. fd_send at T+8. No RAM address other than 0.
- fs_send pulsed during a packet, and a command frame received during a packet → second fs_send ignored, packet bit-exact, cmd_vld correct.
- rst=0 mid-DATA and mid-CMD → all outputs at reset values immediately. After release, a fresh packet and a fresh command complete correctly.

Source files
------------

// File: rtl/usb_dev.sv
// rtl/usb_dev.sv - device-side link endpoint: serial command receiver and nibble packet transmitter
module usb_dev #(
    parameter int RAM_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_rxd,
    output logic [31:0]       cmd,
    output logic              cmd_vld,
    output logic              cmd_err,
    input  logic              fs_send,
    input  logic [3:0]        send_btype,
    input  logic [RAM_AW-1:0] send_len,
    output logic              fd_send,
    output logic              busy,
    output logic [RAM_AW-1:0] ram_rxa,
    input  logic [7:0]        ram_rxd,
    output logic [3:0]        data_txd,
    output logic              data_txen
);

    localparam logic [15:0]       SYNC_WORD = 16'h55D5;
    localparam logic [RAM_AW-1:0] RA_ONE    = {{(RAM_AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {RX_HUNT, RX_CMD, RX_CHK} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_PRE, TX_TYPE, TX_DATA, TX_CSUM} tx_state_t;

    rx_state_t   rx_state, rx_state_nxt;
    logic [14:0] sync_sr, sync_sr_nxt;
    logic [31:0] cmd_sr, cmd_sr_nxt;
    logic [6:0]  chk_sr, chk_sr_nxt;
    logic [4:0]  rx_cnt, rx_cnt_nxt;
    logic [31:0] cmd_nxt;
    logic        cmd_vld_nxt, cmd_err_nxt;
    logic [15:0] sync_shift;
    logic [7:0]  chk_shift;
    logic [7:0]  cmd_xor;

    assign sync_shift = {sync_sr, cmd_rxd};
    assign chk_shift  = {chk_sr, cmd_rxd};
    assign cmd_xor    = cmd_sr[31:24] ^ cmd_sr[23:16] ^ cmd_sr[15:8] ^ cmd_sr[7:0];

    always_comb begin
        rx_state_nxt = rx_state;
        sync_sr_nxt  = sync_sr;
        cmd_sr_nxt   = cmd_sr;
        chk_sr_nxt   = chk_sr;
        rx_cnt_nxt   = rx_cnt;
        cmd_nxt      = cmd;
        cmd_vld_nxt  = 1'b0;
        cmd_err_nxt  = 1'b0;
        case (rx_state)
            RX_HUNT: begin
                sync_sr_nxt = sync_shift[14:0];
                if (sync_shift == SYNC_WORD) begin
                    rx_state_nxt = RX_CMD;
                    rx_cnt_nxt   = 5'd0;
                end
            end
            RX_CMD: begin
                cmd_sr_nxt = {cmd_sr[30:0], cmd_rxd};
                rx_cnt_nxt = rx_cnt + 5'd1;
                if (rx_cnt == 5'd31) begin
                    rx_state_nxt = RX_CHK;
                    rx_cnt_nxt   = 5'd0;
                end
            end
            RX_CHK: begin
                chk_sr_nxt = chk_shift[6:0];
                rx_cnt_nxt = rx_cnt + 5'd1;
                if (rx_cnt == 5'd7) begin
                    // Clearing the sync history keeps payload bits from completing a new sync word.
                    rx_state_nxt = RX_HUNT;
                    sync_sr_nxt  = '0;
                    rx_cnt_nxt   = 5'd0;
                    if (chk_shift == cmd_xor) begin
                        cmd_nxt     = cmd_sr;
                        cmd_vld_nxt = 1'b1;
                    end else begin
                        cmd_err_nxt = 1'b1;
                    end
                end
            end
            default: rx_state_nxt = RX_HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= RX_HUNT;
            sync_sr  <= '0;
            cmd_sr   <= '0;
            chk_sr   <= '0;
            rx_cnt   <= '0;
            cmd      <= '0;
            cmd_vld  <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            sync_sr  <= sync_sr_nxt;
            cmd_sr   <= cmd_sr_nxt;
            chk_sr   <= chk_sr_nxt;
            rx_cnt   <= rx_cnt_nxt;
            cmd      <= cmd_nxt;
            cmd_vld  <= cmd_vld_nxt;
            cmd_err  <= cmd_err_nxt;
        end
    end

    tx_state_t         tx_state, tx_state_nxt;
    logic [1:0]        pre_cnt, pre_cnt_nxt;
    logic              phase, phase_nxt;
    logic [RAM_AW-1:0] byte_cnt, byte_cnt_nxt;
    logic [RAM_AW-1:0] len_q, len_q_nxt;
    logic [RAM_AW-1:0] last_idx;
    logic [RAM_AW-1:0] ram_rxa_nxt;
    logic [3:0]        btype_q, btype_q_nxt;
    logic [7:0]        csum, csum_nxt;
    logic [3:0]        lo_buf, lo_buf_nxt;
    logic [3:0]        data_txd_nxt;
    logic              data_txen_nxt;
    logic              tx_done, tx_done_nxt;
    logic              fd_send_nxt, busy_nxt;

    assign last_idx = len_q - RA_ONE;

    // Byte i is addressed on the high-nibble cycle of byte i-1, so ram_rxd holds it on its own high-nibble edge.
    always_comb begin
        tx_state_nxt  = tx_state;
        pre_cnt_nxt   = pre_cnt;
        phase_nxt     = phase;
        byte_cnt_nxt  = byte_cnt;
        len_q_nxt     = len_q;
        btype_q_nxt   = btype_q;
        csum_nxt      = csum;
        lo_buf_nxt    = lo_buf;
        ram_rxa_nxt   = ram_rxa;
        data_txd_nxt  = 4'h0;
        data_txen_nxt = 1'b0;
        tx_done_nxt   = 1'b0;
        fd_send_nxt   = tx_done;
        busy_nxt      = tx_done ? 1'b0 : busy;
        case (tx_state)
            TX_IDLE: begin
                ram_rxa_nxt = '0;
                if (fs_send) begin
                    tx_state_nxt = TX_PRE;
                    pre_cnt_nxt  = 2'd0;
                    btype_q_nxt  = send_btype;
                    len_q_nxt    = send_len;
                    csum_nxt     = 8'h00;
                    busy_nxt     = 1'b1;
                end
            end
            TX_PRE: begin
                data_txen_nxt = 1'b1;
                data_txd_nxt  = (pre_cnt == 2'd3) ? 4'hD : 4'h5;
                pre_cnt_nxt   = pre_cnt + 2'd1;
                if (pre_cnt == 2'd3) tx_state_nxt = TX_TYPE;
            end
            TX_TYPE: begin
                data_txen_nxt = 1'b1;
                data_txd_nxt  = btype_q;
                byte_cnt_nxt  = '0;
                phase_nxt     = 1'b0;
                tx_state_nxt  = (len_q == '0) ? TX_CSUM : TX_DATA;
            end
            TX_DATA: begin
                data_txen_nxt = 1'b1;
                if (!phase) begin
                    data_txd_nxt = ram_rxd[7:4];
                    lo_buf_nxt   = ram_rxd[3:0];
                    csum_nxt     = csum ^ ram_rxd;
                    phase_nxt    = 1'b1;
                    if (byte_cnt != last_idx) ram_rxa_nxt = byte_cnt + RA_ONE;
                end else begin
                    data_txd_nxt = lo_buf;
                    phase_nxt    = 1'b0;
                    byte_cnt_nxt = byte_cnt + RA_ONE;
                    if (byte_cnt == last_idx) tx_state_nxt = TX_CSUM;
                end
            end
            TX_CSUM: begin
                data_txen_nxt = 1'b1;
                if (!phase) begin
                    data_txd_nxt = csum[7:4];
                    phase_nxt    = 1'b1;
                end else begin
                    // Returning to IDLE one cycle early lets the next fs_send land on the fd_send edge.
                    data_txd_nxt = csum[3:0];
                    phase_nxt    = 1'b0;
                    tx_state_nxt = TX_IDLE;
                    tx_done_nxt  = 1'b1;
                    ram_rxa_nxt  = '0;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state  <= TX_IDLE;
            pre_cnt   <= '0;
            phase     <= 1'b0;
            byte_cnt  <= '0;
            len_q     <= '0;
            btype_q   <= '0;
            csum      <= '0;
            lo_buf    <= '0;
            ram_rxa   <= '0;
            data_txd  <= '0;
            data_txen <= 1'b0;
            tx_done   <= 1'b0;
            fd_send   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            tx_state  <= tx_state_nxt;
            pre_cnt   <= pre_cnt_nxt;
            phase     <= phase_nxt;
            byte_cnt  <= byte_cnt_nxt;
            len_q     <= len_q_nxt;
            btype_q   <= btype_q_nxt;
            csum      <= csum_nxt;
            lo_buf    <= lo_buf_nxt;
            ram_rxa   <= ram_rxa_nxt;
            data_txd  <= data_txd_nxt;
            data_txen <= data_txen_nxt;
            tx_done   <= tx_done_nxt;
            fd_send   <= fd_send_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_usb_dev.sv
// tb/tb_usb_dev.sv - self-checking bench for usb_dev
module tb_usb_dev;

    localparam int RAM_AW = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cmd_rxd = 1'b1;
    logic [31:0]       cmd;
    logic              cmd_vld, cmd_err;
    logic              fs_send = 1'b0;
    logic [3:0]        send_btype = 4'h0;
    logic [RAM_AW-1:0] send_len = '0;
    logic              fd_send, busy;
    logic [RAM_AW-1:0] ram_rxa;
    logic [7:0]        ram_rxd;
    logic [3:0]        data_txd;
    logic              data_txen;

    logic [7:0] mem [0:(1<<RAM_AW)-1];
    int n_checks = 0;
    int n_errors = 0;
    int vld_cnt = 0;
    int err_cnt = 0;
    int fd_cnt = 0;
    logic [63:0] all_outs;

    usb_dev #(.RAM_AW(RAM_AW)) dut (
        .clk(clk), .rst(rst), .cmd_rxd(cmd_rxd), .cmd(cmd), .cmd_vld(cmd_vld),
        .cmd_err(cmd_err), .fs_send(fs_send), .send_btype(send_btype), .send_len(send_len),
        .fd_send(fd_send), .busy(busy), .ram_rxa(ram_rxa), .ram_rxd(ram_rxd),
        .data_txd(data_txd), .data_txen(data_txen)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ram_rxd <= mem[ram_rxa];

    always @(negedge clk) begin
        if (cmd_vld) vld_cnt++;
        if (cmd_err) err_cnt++;
        if (fd_send) fd_cnt++;
    end

    assign all_outs = {11'b0, cmd, cmd_vld, cmd_err, fd_send, busy, ram_rxa, data_txd, data_txen};

    typedef struct packed {
        logic [3:0]        btype;
        logic [RAM_AW-1:0] len;
        logic [31:0]       data;
        logic [7:0]        n_nib;
        logic [63:0]       exp;
    } pkt_vec_t;

    pkt_vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_pkt(input int v);
        int max_a;
        int lim;
        for (int i = 0; i < 4; i++) mem[i] = vecs[v].data[31-8*i -: 8];
        max_a = 0;
        lim = (vecs[v].len == 0) ? 0 : int'(vecs[v].len) - 1;
        @(negedge clk);
        fs_send = 1'b1;
        send_btype = vecs[v].btype;
        send_len = vecs[v].len;
        @(negedge clk);
        fs_send = 1'b0;
        check($sformatf("pkt%0d_start", v), {busy, data_txen}, 2'b10);
        for (int k = 0; k < int'(vecs[v].n_nib); k++) begin
            @(negedge clk);
            if (int'(ram_rxa) > max_a) max_a = int'(ram_rxa);
            check($sformatf("pkt%0d_nib%0d", v, k), {busy, data_txen, data_txd, fd_send},
                  {1'b1, 1'b1, vecs[v].exp[63-4*k -: 4], 1'b0});
        end
        @(negedge clk);
        check($sformatf("pkt%0d_done", v), {fd_send, busy, data_txen, data_txd}, 7'b1000000);
        check($sformatf("pkt%0d_rxa_max", v), max_a, lim);
        @(negedge clk);
        check($sformatf("pkt%0d_idle", v), {fd_send, data_txen, ram_rxa}, '0);
    endtask

    task automatic send_frame(input logic [31:0] c, input logic [7:0] k);
        logic [55:0] bits;
        bits = {16'h55D5, c, k};
        for (int j = 0; j < 56; j++) begin
            @(negedge clk);
            cmd_rxd = bits[55-j];
        end
    endtask

    task automatic finish_frame(input string name, input logic [1:0] exp_ve, input logic [31:0] exp_cmd);
        @(negedge clk);
        check({name, "_pulse"}, {cmd_vld, cmd_err}, exp_ve);
        check({name, "_cmd"}, cmd, exp_cmd);
        cmd_rxd = 1'b1;
        @(negedge clk);
        check({name, "_single"}, {cmd_vld, cmd_err}, 2'b00);
    endtask

    initial begin
        int v0, e0, f0;
        logic [55:0] rbits;

        vecs[0] = '{btype: 4'h3, len: 12'd3, data: 32'hA1B2C300, n_nib: 8'd13, exp: 64'h555D3A1B2C3D0000};
        vecs[1] = '{btype: 4'hF, len: 12'd0, data: 32'h00000000, n_nib: 8'd7,  exp: 64'h555DF00000000000};
        vecs[2] = '{btype: 4'h1, len: 12'd1, data: 32'h7E000000, n_nib: 8'd9,  exp: 64'h555D17E7E0000000};
        vecs[3] = '{btype: 4'hA, len: 12'd4, data: 32'h01020408, n_nib: 8'd15, exp: 64'h555DA010204080F0};
        vecs[4] = '{btype: 4'h6, len: 12'd2, data: 32'hFFFF0000, n_nib: 8'd11, exp: 64'h555D6FFFF0000000};
        for (int i = 0; i < (1<<RAM_AW); i++) mem[i] = 8'hEE;

        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs, '0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) run_pkt(v);

        v0 = vld_cnt;
        send_frame(32'h12345678, 8'h08);
        finish_frame("rx_good", 2'b10, 32'h12345678);
        check("rx_good_count", vld_cnt - v0, 1);

        v0 = vld_cnt;
        send_frame(32'hDEADBEEF, 8'h22);
        send_frame(32'hCAFEF00D, 8'hC9);
        finish_frame("rx_b2b", 2'b10, 32'hCAFEF00D);
        check("rx_b2b_count", vld_cnt - v0, 2);

        e0 = err_cnt;
        send_frame(32'h12345678, 8'h09);
        finish_frame("rx_bad", 2'b01, 32'hCAFEF00D);
        check("rx_bad_count", err_cnt - e0, 1);
        send_frame(32'hDEADBEEF, 8'h22);
        finish_frame("rx_after_bad", 2'b10, 32'hDEADBEEF);

        f0 = fd_cnt;
        v0 = vld_cnt;
        fork
            run_pkt(0);
            begin
                repeat (5) @(negedge clk);
                fs_send = 1'b1;
                @(negedge clk);
                fs_send = 1'b0;
            end
            begin
                send_frame(32'hA5A5A5A5, 8'h00);
                finish_frame("rx_during_pkt", 2'b10, 32'hA5A5A5A5);
            end
        join
        check("dup_fs_ignored", {busy, data_txen}, 2'b00);
        check("dup_fs_fd_count", fd_cnt - f0, 1);
        check("dup_fs_vld_count", vld_cnt - v0, 1);

        for (int i = 0; i < 4; i++) mem[i] = vecs[3].data[31-8*i -: 8];
        rbits = {16'h55D5, 32'h0F0F0F0F, 8'h00};
        for (int j = 0; j < 25; j++) begin
            @(negedge clk);
            cmd_rxd = rbits[55-j];
            if (j == 14) begin
                fs_send = 1'b1;
                send_btype = 4'hA;
                send_len = 12'd4;
            end
            if (j == 15) fs_send = 1'b0;
        end
        @(negedge clk);
        check("mid_data_state", {busy, data_txen, data_txd, ram_rxa}, {1'b1, 1'b1, 4'h0, 12'd3});
        rst = 1'b0;
        #1;
        check("mid_reset_outputs", all_outs, '0);
        f0 = fd_cnt;
        v0 = vld_cnt;
        cmd_rxd = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_fd_vld", {fd_cnt - f0, vld_cnt - v0}, '0);
        check("abort_idle_outputs", all_outs, '0);

        fork
            run_pkt(0);
            begin
                send_frame(32'hDEADBEEF, 8'h22);
                finish_frame("rx_after_reset", 2'b10, 32'hDEADBEEF);
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
